// File: rtl/cache_pkg.sv
// Shared types for the cache replacement path: LRU array commands
// and the replacement sequencer state encoding.
package cache_pkg;

    typedef enum logic [1:0] {
        LRU_INIT   = 2'b00,
        LRU_TOUCH  = 2'b01,
        LRU_ROTATE = 2'b10,
        LRU_IDLE   = 2'b11
    } lru_cmd_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_VICTIM,
        S_TOUCH,
        S_RESP
    } repl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/lru_replace_ctrl.sv
// Replacement sequencer: turns hit/miss lookups into LRU array
// commands, returns the way to use and counts hits and misses.
module lru_replace_ctrl
    import cache_pkg::*;
#(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7,
    parameter int CNT_W      = 32,
    localparam int WAY_W     = $clog2(ASSOC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_SIZE-1:0] req_index,
    input  logic                  req_hit,
    input  logic [WAY_W-1:0]      req_way,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WAY_W-1:0]      rsp_way,
    output logic [INDEX_SIZE-1:0] rsp_index,
    output logic                  rsp_miss,
    input  logic                  flush,
    output logic [1:0]            replace,
    output logic [INDEX_SIZE-1:0] index,
    output logic [WAY_W-1:0]      assoc,
    input  logic [WAY_W-1:0]      lru,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    repl_state_e           state_q, state_d;
    logic [INDEX_SIZE-1:0] index_q, index_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic                  miss_q, miss_d;
    logic                  fpend_q, fpend_d;
    lru_cmd_e              cmd;
    logic                  accept;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            index_q <= '0;
            way_q   <= '0;
            miss_q  <= 1'b0;
            fpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            way_q   <= way_d;
            miss_q  <= miss_d;
            fpend_q <= fpend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:   state_d = S_IDLE;
            S_IDLE: begin
                if (flush) begin
                    state_d = S_INIT;
                end else if (accept) begin
                    state_d = req_hit ? S_TOUCH : S_VICTIM;
                end
            end
            S_VICTIM: state_d = S_TOUCH;
            S_TOUCH:  state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = (fpend_q || flush) ? S_INIT : S_IDLE;
                end
            end
            default:  state_d = S_INIT;
        endcase
    end

    // Victim is captured at the end of VICTIM so TOUCH promotes it.
    always_comb begin
        index_d = index_q;
        way_d   = way_q;
        miss_d  = miss_q;
        fpend_d = fpend_q;
        if (accept) begin
            index_d = req_index;
            way_d   = req_way;
            miss_d  = !req_hit;
        end
        if (state_q == S_VICTIM) begin
            way_d = lru;
        end
        if (state_q == S_INIT) begin
            fpend_d = 1'b0;
        end else if (flush && state_q != S_IDLE) begin
            fpend_d = 1'b1;
        end
    end

    always_comb begin
        cmd       = LRU_IDLE;
        req_ready = (state_q == S_IDLE) && !flush && !fpend_q;
        rsp_valid = (state_q == S_RESP);
        if (!rst) begin
            if (state_q == S_INIT) begin
                cmd = LRU_INIT;
            end else if (state_q == S_TOUCH) begin
                cmd = LRU_TOUCH;
            end
        end
    end

    assign replace   = cmd;
    assign index     = index_q;
    assign assoc     = way_q;
    assign rsp_way   = way_q;
    assign rsp_index = index_q;
    assign rsp_miss  = miss_q;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && req_hit),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && !req_hit),
        .count (miss_count)
    );

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Directed bench for lru_replace_ctrl with a stub LRU array
// and a 4-bit counter build to reach saturation.
module tb_lru_replace_ctrl;

    localparam int WW = 3;
    localparam int IW = 7;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_index = '0;
    logic          req_hit = 1'b0;
    logic [WW-1:0] req_way = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [WW-1:0] rsp_way;
    logic [IW-1:0] rsp_index;
    logic          rsp_miss;
    logic          flush = 1'b0;
    logic [1:0]    replace;
    logic [IW-1:0] index;
    logic [WW-1:0] assoc;
    logic [WW-1:0] lru;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Stub array: set 9 reports way 6, others report index[2:0]^1.
    always_comb begin
        lru = index[2:0] ^ 3'd1;
        if (index == 7'd9) lru = 3'd6;
    end

    lru_replace_ctrl #(
        .ASSOC(8), .INDEX_SIZE(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_hit(req_hit), .req_way(req_way),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_way(rsp_way), .rsp_index(rsp_index), .rsp_miss(rsp_miss),
        .flush(flush), .replace(replace), .index(index), .assoc(assoc),
        .lru(lru), .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({replace, req_ready, rsp_valid, index, assoc, rsp_way, rsp_miss}
            !== {2'b11, 1'b0, 1'b0, 7'd0, 3'd0, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_vals got rep=%b rdy=%b rv=%b idx=%0d as=%0d want 11/0/0/0/0",
                     replace, req_ready, rsp_valid, index, assoc);
        end
        tests++;
        if ({hit_count, miss_count} !== 8'h00) begin
            fails++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_count, miss_count);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({replace, req_ready} !== {2'b00, 1'b0}) begin
            fails++;
            $display("FAIL init_cycle got rep=%b rdy=%b want 00/0", replace, req_ready);
        end
        @(negedge clk);
        tests++;
        if ({replace, req_ready} !== {2'b11, 1'b1}) begin
            fails++;
            $display("FAIL after_init got rep=%b rdy=%b want 11/1", replace, req_ready);
        end
    endtask

    task automatic test_hit();
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL hit_ready got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_hit = 1'b1; req_index = 7'd5; req_way = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if ({replace, index, assoc, rsp_valid} !== {2'b01, 7'd5, 3'd3, 1'b0}) begin
            fails++;
            $display("FAIL hit_touch got rep=%b idx=%0d as=%0d rv=%b want 01/5/3/0",
                     replace, index, assoc, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_way, rsp_index, rsp_miss, replace}
            !== {1'b1, 3'd3, 7'd5, 1'b0, 2'b11}) begin
            fails++;
            $display("FAIL hit_rsp got rv=%b way=%0d idx=%0d miss=%b want 1/3/5/0",
                     rsp_valid, rsp_way, rsp_index, rsp_miss);
        end
        tests++;
        if (hit_count !== 4'd1 || miss_count !== 4'd0) begin
            fails++;
            $display("FAIL hit_cnt got %0d/%0d want 1/0", hit_count, miss_count);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL hit_done got rv=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_miss();
        req_valid = 1'b1; req_hit = 1'b0; req_index = 7'd9; req_way = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if ({replace, index, rsp_valid} !== {2'b11, 7'd9, 1'b0}) begin
            fails++;
            $display("FAIL miss_victim got rep=%b idx=%0d rv=%b want 11/9/0",
                     replace, index, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if ({replace, index, assoc, rsp_valid} !== {2'b01, 7'd9, 3'd6, 1'b0}) begin
            fails++;
            $display("FAIL miss_touch got rep=%b idx=%0d as=%0d want 01/9/6",
                     replace, index, assoc);
        end
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_way, rsp_index, rsp_miss} !== {1'b1, 3'd6, 7'd9, 1'b1}) begin
            fails++;
            $display("FAIL miss_rsp got rv=%b way=%0d idx=%0d miss=%b want 1/6/9/1",
                     rsp_valid, rsp_way, rsp_index, rsp_miss);
        end
        tests++;
        if (miss_count !== 4'd1 || hit_count !== 4'd1) begin
            fails++;
            $display("FAIL miss_cnt got h=%0d m=%0d want 1/1", hit_count, miss_count);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        req_valid = 1'b1; req_hit = 1'b1; req_index = 7'd2; req_way = 3'd7;
        @(negedge clk);
        req_index = 7'd1; req_way = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({rsp_valid, rsp_way, rsp_index, rsp_miss, req_ready, replace}
                !== {1'b1, 3'd7, 7'd2, 1'b0, 1'b0, 2'b11}) begin
                fails++;
                $display("FAIL stall_%0d got rv=%b way=%0d idx=%0d rdy=%b rep=%b want 1/7/2/0/11",
                         i, rsp_valid, rsp_way, rsp_index, req_ready, replace);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, req_ready, hit_count} !== {1'b0, 1'b1, 4'd2}) begin
            fails++;
            $display("FAIL stall_release got rv=%b rdy=%b hits=%0d want 0/1/2",
                     rsp_valid, req_ready, hit_count);
        end
    endtask

    task automatic test_flush_victim();
        req_valid = 1'b1; req_hit = 1'b0; req_index = 7'd4; req_way = 3'd0;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if ({replace, assoc} !== {2'b01, 3'd5}) begin
            fails++;
            $display("FAIL fv_touch got rep=%b as=%0d want 01/5", replace, assoc);
        end
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_way, rsp_index, rsp_miss} !== {1'b1, 3'd5, 7'd4, 1'b1}) begin
            fails++;
            $display("FAIL fv_rsp got rv=%b way=%0d idx=%0d miss=%b want 1/5/4/1",
                     rsp_valid, rsp_way, rsp_index, rsp_miss);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if ({replace, rsp_valid, req_ready} !== {2'b00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL fv_init got rep=%b rv=%b rdy=%b want 00/0/0",
                     replace, rsp_valid, req_ready);
        end
        @(negedge clk);
        tests++;
        if ({replace, req_ready, miss_count} !== {2'b11, 1'b1, 4'd2}) begin
            fails++;
            $display("FAIL fv_idle got rep=%b rdy=%b miss=%0d want 11/1/2",
                     replace, req_ready, miss_count);
        end
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        req_valid = 1'b1; req_hit = 1'b1; req_index = 7'd3; req_way = 3'd1;
        #1;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL fi_ready got %b want 0", req_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        tests++;
        if ({replace, rsp_valid, hit_count} !== {2'b00, 1'b0, 4'd2}) begin
            fails++;
            $display("FAIL fi_init got rep=%b rv=%b hits=%0d want 00/0/2",
                     replace, rsp_valid, hit_count);
        end
        @(negedge clk);
        tests++;
        if ({replace, req_ready} !== {2'b11, 1'b1}) begin
            fails++;
            $display("FAIL fi_idle got rep=%b rdy=%b want 11/1", replace, req_ready);
        end
    endtask

    task automatic test_saturate();
        rsp_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            int budget;
            req_valid = 1'b1; req_hit = 1'b1;
            req_index = 7'(n); req_way = 3'(n);
            @(negedge clk);
            req_valid = 1'b0;
            budget = 0;
            while (rsp_valid !== 1'b1 && budget < 8) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 8) begin
                tests++;
                fails++;
                $display("FAIL sat_timeout req %0d rv=%b want 1", n, rsp_valid);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        tests++;
        if ({hit_count, miss_count} !== {4'd15, 4'd2}) begin
            fails++;
            $display("FAIL sat_cnt got h=%0d m=%0d want 15/2", hit_count, miss_count);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_hit = 1'b1; req_index = 7'd6; req_way = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({rsp_valid, rsp_way} !== {1'b1, 3'd2}) begin
            fails++;
            $display("FAIL rm_rsp got rv=%b way=%0d want 1/2", rsp_valid, rsp_way);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({rsp_valid, replace, req_ready, hit_count, miss_count}
            !== {1'b0, 2'b11, 1'b0, 4'd0, 4'd0}) begin
            fails++;
            $display("FAIL rm_reset got rv=%b rep=%b rdy=%b h=%0d m=%0d want 0/11/0/0/0",
                     rsp_valid, replace, req_ready, hit_count, miss_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({replace, req_ready, rsp_valid} !== {2'b00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rm_init got rep=%b rdy=%b rv=%b want 00/0/0",
                     replace, req_ready, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if ({replace, req_ready} !== {2'b11, 1'b1}) begin
            fails++;
            $display("FAIL rm_idle got rep=%b rdy=%b want 11/1", replace, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_stall();
        test_flush_victim();
        test_flush_idle();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lru_replace_ctrl.md
# lru_replace_ctrl

Replacement sequencer that drives the cache core's per-set LRU array. Accepts one lookup outcome per transaction (hit with way, or miss), issues the matching LRU command sequence, returns the way the cache must use, and counts hits and misses. Sits between the cache tag/miss FSM and the LRU array. It drives the array's command, index and way inputs and reads back its combinational victim output.

## Interface
- ASSOC, 8, ways per set; power of two, ≥2; WAY_W = $clog2(ASSOC)
- INDEX_SIZE, 7, set-index width
- CNT_W, 32, hit/miss counter width
- clk  in  1  clock, all flops on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_index  in  INDEX_SIZE  set index
- req_hit  in  1  1 = hit, 0 = miss
- req_way  in  WAY_W  hit way; ignored on miss
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_way  out  WAY_W  way to use (hit way or victim)
- rsp_index  out  INDEX_SIZE  echoed set index
- rsp_miss  out  1  echoed miss flag
- flush  in  1  re-initialise all LRU state
- replace  out  2  LRU command: 00 init-all, 01 touch, 10 rotate (never issued), 11 idle
- index  out  INDEX_SIZE  LRU set select
- assoc  out  WAY_W  LRU way to touch
- lru  in  WAY_W  LRU victim way for `index`, combinational
- hit_count, miss_count  out  CNT_W  saturating counters

## Operation
- FSM states: INIT, IDLE, VICTIM, TOUCH, RESP.
- INIT: replace=00 for exactly one cycle, then go to IDLE.
- IDLE: req_ready = !flush && !flush_pend. On accept, latch index, hit and way. Go to TOUCH on a hit and VICTIM on a miss.
- VICTIM: index=latched index, replace=11. Register `lru` into the way register at the cycle's end. Go to TOUCH.
- TOUCH: replace=01, index=latched index, assoc=way register, so the used way becomes MRU. Go to RESP.
- RESP: rsp_valid=1 with rsp_way, rsp_index and rsp_miss from the registers. Hold all of them stable until rsp_ready, then go to IDLE.
- In every state other than INIT and TOUCH, replace=11. The index and assoc outputs hold the latched registers.
- flush in IDLE: go to INIT next cycle. flush has priority over a simultaneous req_valid, which is not accepted.
- flush in VICTIM, TOUCH or RESP: set flush_pend. The transaction completes normally; then RESP goes to INIT instead of IDLE. INIT clears flush_pend.
- Counters: on accept, increment hit_count if req_hit, else miss_count. Each saturates at all-ones, has no wrap, and is cleared only by rst (flush does not clear it).
- rst, including mid-transaction: the FSM goes to INIT and any pending response is dropped.

## Timing
- Reset values: state=INIT, req_ready=0, rsp_valid=0, rsp_way=0, rsp_index=0, rsp_miss=0, replace=11, index=0, assoc=0, counters=0, flush_pend=0.
- First cycle after rst deasserts: replace=00. req_ready rises one cycle later.
- Hit accepted at cycle T: TOUCH at T+1, rsp_valid at T+2.
- Miss accepted at cycle T: VICTIM at T+1, TOUCH at T+2, rsp_valid at T+3.
- rsp_ready sampled high at cycle R: rsp_valid low and req_ready high at R+1. There is no accept in the same cycle as a response handshake.
- One transaction is in flight at a time. Throughput is 1 request per 3 cycles on hits and 4 on misses, with rsp_ready held high.
- The LRU array updates on the clk edge ending TOUCH. The victim read in VICTIM therefore always sees state after all prior touches.

## Structure
- cache_pkg: enum lru_cmd_e {LRU_INIT=2'b00, LRU_TOUCH=2'b01, LRU_ROTATE=2'b10, LRU_IDLE=2'b11}, and state enum repl_state_e.
- Sub-module sat_counter #(W): inc input, async-reset, saturating. Instantiated twice, for hits and misses.
- The FSM and registers stay in lru_replace_ctrl. The LRU array is instantiated by the parent, not inside this block.

## Test plan
- Reset release: replace=00 for exactly one cycle, req_ready=1 the next cycle, counters=0.
- Hit: index=5, way=3 → TOUCH shows replace=01, index=5, assoc=3; rsp_valid at T+2 with rsp_way=3, rsp_miss=0; hit_count=1.
- Miss with array model returning lru=6 for index=9 → TOUCH assoc=6; rsp_way=6, rsp_index=9, rsp_miss=1 at T+3; miss_count=1.
- rsp_ready held low 5 cycles → rsp fields stable, req_ready=0, no further replace=01; release → IDLE next cycle.
- flush pulse during VICTIM → transaction completes, then one replace=00 cycle, then IDLE; flush together with req_valid in IDLE → request not accepted.
- With CNT_W=4, 20 hits → hit_count stays 15; assert rst during RESP → rsp_valid=0 immediately, INIT follows.
